fft_sched: RTL and testbench

Control sequencer for the 4-point serial FFT datapath, clocked by `fastclock`. It synchronises the `readyin` sample strobe and counts four input samples into the data store. It then schedules the two radix-2 stages, four butterflies in total, on the single shared multiplier and ALU. Finally it streams the results out in bit-reversed-corrected order. It drives only select, enable and address lines; no data passes through it.

---
 rtl/fft_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_sched.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sched.sv
// Control sequencer for the 4-point serial FFT datapath: counts in four samples,
// schedules four butterflies on the shared multiplier/ALU, then streams results out.
module fft_sched (
    input  logic       fastclock,
    input  logic       n_rst,
    input  logic       readyin,
    output logic       load_en,
    output logic [1:0] in_addr,
    output logic [1:0] rd_a_addr,
    output logic [1:0] rd_b_addr,
    output logic [1:0] tw_sel,
    output logic       mul_en,
    output logic       alu_op,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic       out_valid,
    output logic [1:0] out_addr,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned AW      = 2;
    localparam int unsigned FRAME   = 4;
    localparam int unsigned PH_LAST = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STAGE1 = 3'd2,
        STAGE2 = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          bf, bf_n;
    logic [1:0]    ph, ph_n;
    logic          s1, s2, s3;
    logic          rise;

    logic [AW-1:0] op_a, op_b;
    logic          op_w;

    logic          load_en_d, mul_en_d, alu_op_d, wr_en_d;
    logic          out_valid_d, busy_d, done_d, overrun_d;
    logic [AW-1:0] in_addr_d, rd_a_d, rd_b_d, tw_d, wr_addr_d, out_addr_d;

    // Three-flop synchroniser on the asynchronous sample strobe
    always_ff @(posedge fastclock or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= readyin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // State register; outputs are decoded from the current state and registered here
    always_ff @(posedge fastclock or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bf        <= 1'b0;
            ph        <= '0;
            load_en   <= 1'b0;
            in_addr   <= '0;
            rd_a_addr <= '0;
            rd_b_addr <= '0;
            tw_sel    <= '0;
            mul_en    <= 1'b0;
            alu_op    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bf        <= bf_n;
            ph        <= ph_n;
            load_en   <= load_en_d;
            in_addr   <= in_addr_d;
            rd_a_addr <= rd_a_d;
            rd_b_addr <= rd_b_d;
            tw_sel    <= tw_d;
            mul_en    <= mul_en_d;
            alu_op    <= alu_op_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            out_valid <= out_valid_d;
            out_addr  <= out_addr_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
        end
    end

    // Next-state: sample count, butterfly index and phase
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bf_n    = bf;
        ph_n    = ph;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = LOAD;
                    cnt_n   = AW'(1);
                end
            end
            LOAD: begin
                if (rise) begin
                    cnt_n = cnt + AW'(1);
                    if (cnt == AW'(FRAME - 1)) begin
                        state_n = STAGE1;
                        bf_n    = 1'b0;
                        ph_n    = '0;
                    end
                end
            end
            STAGE1, STAGE2: begin
                if (ph == 2'(PH_LAST)) begin
                    ph_n = '0;
                    bf_n = ~bf;
                    if (bf) begin
                        state_n = (state == STAGE1) ? STAGE2 : UNLOAD;
                        cnt_n   = '0;
                    end
                end else begin
                    ph_n = ph + 2'(1);
                end
            end
            UNLOAD: begin
                cnt_n = cnt + AW'(1);
                if (cnt == AW'(FRAME - 1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode; butterfly operands come from the stage and butterfly index
    always_comb begin
        load_en_d   = 1'b0;
        in_addr_d   = '0;
        rd_a_d      = '0;
        rd_b_d      = '0;
        tw_d        = '0;
        mul_en_d    = 1'b0;
        alu_op_d    = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        out_valid_d = 1'b0;
        out_addr_d  = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        op_w        = 1'b0;

        case ({state == STAGE2, bf})
            2'b00: begin op_a = AW'(0); op_b = AW'(2); end
            2'b01: begin op_a = AW'(1); op_b = AW'(3); end
            2'b10: begin op_a = AW'(0); op_b = AW'(1); end
            default: begin op_a = AW'(2); op_b = AW'(3); op_w = 1'b1; end
        endcase

        case (state)
            IDLE: begin
                if (rise) begin
                    load_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            LOAD: begin
                busy_d = 1'b1;
                if (rise) begin
                    load_en_d = 1'b1;
                    in_addr_d = cnt;
                end
            end
            STAGE1, STAGE2: begin
                busy_d    = 1'b1;
                overrun_d = rise;
                rd_a_d    = op_a;
                rd_b_d    = op_b;
                case (ph)
                    2'd0: begin
                        mul_en_d = 1'b1;
                        tw_d     = {1'b0, op_w};
                    end
                    2'd1: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = op_a;
                    end
                    default: begin
                        alu_op_d  = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = op_b;
                    end
                endcase
            end
            UNLOAD: begin
                busy_d      = 1'b1;
                overrun_d   = rise;
                out_valid_d = 1'b1;
                out_addr_d  = {cnt[0], cnt[1]};
                done_d      = (cnt == AW'(FRAME - 1));
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: directed scenarios plus random strobe trains,
// compared cycle by cycle against a frame-level reference model.
module tb_fft_sched;

    logic       fastclock = 1'b0;
    logic       n_rst     = 1'b0;
    logic       readyin   = 1'b0;
    logic       load_en, mul_en, alu_op, wr_en, out_valid, busy, done, overrun;
    logic [1:0] in_addr, rd_a_addr, rd_b_addr, tw_sel, wr_addr, out_addr;

    fft_sched dut (
        .fastclock (fastclock),
        .n_rst     (n_rst),
        .readyin   (readyin),
        .load_en   (load_en),
        .in_addr   (in_addr),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .tw_sel    (tw_sel),
        .mul_en    (mul_en),
        .alu_op    (alu_op),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 fastclock = ~fastclock;

    logic [19:0] obs;
    logic [19:0] exp_vec = '0;
    assign obs = {load_en, in_addr, rd_a_addr, rd_b_addr, tw_sel, mul_en, alu_op,
                  wr_en, wr_addr, out_valid, out_addr, busy, done, overrun};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: strobe history, loads in the current frame, 4th-load cycle
    bit p1 = 0, p2 = 0, p3 = 0;
    int m = 0;
    int nloads = 0;
    int last_l = -100;
    bit active = 0;

    int unsigned bfa[4] = '{0, 1, 0, 2};
    int unsigned bfb[4] = '{2, 3, 1, 3};
    int unsigned bfw[4] = '{0, 0, 0, 1};
    int unsigned ord[4] = '{0, 2, 1, 3};

    logic rq[$];

    task automatic model_tick(input logic rin);
        logic       e_load, e_mul, e_alu, e_wr, e_ov, e_valid, e_busy, e_done, edge_seen;
        logic [1:0] e_in, e_ra, e_rb, e_tw, e_wa, e_oa;
        int j, k, ph;
        {e_load, e_mul, e_alu, e_wr, e_ov, e_valid, e_busy, e_done} = '0;
        {e_in, e_ra, e_rb, e_tw, e_wa, e_oa} = '0;
        if (!n_rst) begin
            p1 = 0; p2 = 0; p3 = 0; m = 0; nloads = 0; active = 0; last_l = -100;
            exp_vec = '0;
            return;
        end
        m++;
        edge_seen = p2 & ~p3;
        p3 = p2; p2 = p1; p1 = rin;
        if (nloads == 4 && m > last_l + 16) begin
            nloads = 0;
            active = 0;
        end
        if (edge_seen) begin
            if (nloads == 4) e_ov = 1'b1;
            else begin
                e_load = 1'b1;
                e_in   = 2'(nloads);
                nloads++;
                active = 1;
                if (nloads == 4) last_l = m;
            end
        end
        e_busy = active;
        if (nloads == 4) begin
            j = m - last_l;
            if (j >= 1 && j <= 12) begin
                k  = (j - 1) / 3;
                ph = (j - 1) % 3;
                e_ra  = 2'(bfa[k]);
                e_rb  = 2'(bfb[k]);
                e_mul = (ph == 0);
                e_tw  = (ph == 0) ? 2'(bfw[k]) : 2'd0;
                e_wr  = (ph != 0);
                e_alu = (ph == 2);
                e_wa  = (ph == 1) ? 2'(bfa[k]) : ((ph == 2) ? 2'(bfb[k]) : 2'd0);
            end else if (j >= 13 && j <= 16) begin
                e_valid = 1'b1;
                e_oa    = 2'(ord[j - 13]);
                e_done  = (j == 16);
            end
        end
        exp_vec = {e_load, e_in, e_ra, e_rb, e_tw, e_mul, e_alu, e_wr, e_wa,
                   e_valid, e_oa, e_busy, e_done, e_ov};
    endtask

    // Drive readyin at the falling edge, model the rising edge, return at the next falling edge
    task automatic run_cycle(input logic rin);
        readyin = rin;
        @(posedge fastclock);
        model_tick(readyin);
        @(negedge fastclock);
    endtask

    task automatic add_pulse(input int hi, input int lo);
        repeat (hi) rq.push_back(1'b1);
        repeat (lo) rq.push_back(1'b0);
    endtask

    task automatic apply_reset;
        readyin = 1'b0;
        n_rst   = 1'b0;
        run_cycle(1'b0);
        run_cycle(1'b0);
        n_rst = 1'b1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) begin
            run_cycle(1'b0);
            n_cmp++;
            if (obs !== 20'h0) begin
                n_bad++;
                $display("FAIL reset_hold m=%0d got=%05h exp=%05h", m, obs, 20'h0);
            end
        end
        n_rst = 1'b1;
        repeat (20) begin
            run_cycle(1'b0);
            n_cmp++;
            if (obs !== 20'h0) begin
                n_bad++;
                $display("FAIL reset_idle m=%0d got=%05h exp=%05h", m, obs, 20'h0);
            end
        end
        repeat (3) begin
            run_cycle(1'b1);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_first_load m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
        end
        n_cmp++;
        if (busy !== 1'b1 || load_en !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_before_reset got busy=%b load_en=%b exp 1 1", busy, load_en);
        end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 20'h0) begin
            n_bad++;
            $display("FAIL async_clear_idle got=%05h exp=%05h", obs, 20'h0);
        end
        run_cycle(1'b0);
        run_cycle(1'b0);
        n_rst = 1'b1;
    endtask

    task automatic test_frame;
        logic [15:0] wr_seq;
        logic [7:0]  ld_seq, out_seq;
        logic [23:0] bf_seq;
        logic        v, prev, busy_after;
        int n_wr, n_ld, n_out, n_bf, n_cmpt, n_done, done_m, load4_m, first_cmpt;
        int rise_q[$];
        int load_q[$];
        wr_seq = '0; ld_seq = '0; out_seq = '0; bf_seq = '0;
        prev = 1'b0; busy_after = 1'b1;
        n_wr = 0; n_ld = 0; n_out = 0; n_bf = 0; n_cmpt = 0; n_done = 0;
        done_m = -10; load4_m = -10; first_cmpt = -1;
        apply_reset();
        rq.delete();
        repeat (4) add_pulse(3, 3);
        add_pulse(0, 20);
        while (rq.size() > 0) begin
            v = rq.pop_front();
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL frame_cycle m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (v && !prev) rise_q.push_back(m);
            prev = v;
            if (load_en === 1'b1) begin
                load_q.push_back(m);
                ld_seq = {ld_seq[5:0], in_addr};
                n_ld++;
                load4_m = m;
            end
            if (mul_en === 1'b1) begin
                bf_seq = {bf_seq[17:0], rd_a_addr, rd_b_addr, tw_sel};
                n_bf++;
            end
            if (mul_en === 1'b1 || wr_en === 1'b1) begin
                if (first_cmpt < 0) first_cmpt = m;
                n_cmpt++;
            end
            if (wr_en === 1'b1) begin
                wr_seq = {wr_seq[13:0], wr_addr};
                n_wr++;
            end
            if (out_valid === 1'b1) begin
                out_seq = {out_seq[5:0], out_addr};
                n_out++;
            end
            if (m == done_m + 1) busy_after = busy;
            if (done === 1'b1) begin
                n_done++;
                done_m = m;
                n_cmp++;
                if (out_addr !== 2'd3 || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL done_beat got out_addr=%0d out_valid=%b exp 3 1", out_addr, out_valid);
                end
            end
        end
        n_cmp++;
        if (n_ld != 4 || ld_seq !== 8'h1B) begin
            n_bad++;
            $display("FAIL load_seq got n=%0d seq=%02h exp n=4 seq=1b", n_ld, ld_seq);
        end
        if (load_q.size() == 4 && rise_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (load_q[i] - rise_q[i] != 2) begin
                    n_bad++;
                    $display("FAIL load_latency[%0d] got=%0d exp=2", i, load_q[i] - rise_q[i]);
                end
            end
        end
        n_cmp++;
        if (n_bf != 4 || bf_seq !== 24'h21C12D) begin
            n_bad++;
            $display("FAIL butterfly_seq got n=%0d seq=%06h exp n=4 seq=21c12d", n_bf, bf_seq);
        end
        n_cmp++;
        if (n_cmpt != 12 || first_cmpt != load4_m + 1) begin
            n_bad++;
            $display("FAIL compute_window got n=%0d start=%0d exp n=12 start=%0d", n_cmpt, first_cmpt, load4_m + 1);
        end
        n_cmp++;
        if (n_wr != 8 || wr_seq !== 16'h271B) begin
            n_bad++;
            $display("FAIL wr_addr_seq got n=%0d seq=%04h exp n=8 seq=271b", n_wr, wr_seq);
        end
        n_cmp++;
        if (n_out != 4 || out_seq !== 8'h27) begin
            n_bad++;
            $display("FAIL out_addr_seq got n=%0d seq=%02h exp n=4 seq=27", n_out, out_seq);
        end
        n_cmp++;
        if (n_done != 1 || done_m != load4_m + 16) begin
            n_bad++;
            $display("FAIL done_timing got n=%0d at=%0d exp n=1 at=%0d", n_done, done_m, load4_m + 16);
        end
        n_cmp++;
        if (busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_done got=%b exp=0", busy_after);
        end
    endtask

    task automatic test_overrun;
        logic [15:0] wr_seq;
        int n_ov, ov_m, n_ld, load4_m, n_done, first_after;
        logic v;
        wr_seq = '0; n_ov = 0; ov_m = -1; n_ld = 0; load4_m = -10; n_done = 0; first_after = -1;
        apply_reset();
        rq.delete();
        repeat (3) add_pulse(3, 3);
        add_pulse(3, 6);
        add_pulse(3, 20);
        add_pulse(3, 3);
        add_pulse(0, 10);
        while (rq.size() > 0) begin
            v = rq.pop_front();
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL overrun_cycle m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (overrun === 1'b1) begin n_ov++; ov_m = m; end
            if (wr_en === 1'b1) wr_seq = {wr_seq[13:0], wr_addr};
            if (done === 1'b1) n_done++;
            if (load_en === 1'b1) begin
                n_ld++;
                if (n_ld == 4) load4_m = m;
                if (n_ld == 5) first_after = int'(in_addr);
            end
        end
        n_cmp++;
        if (n_ov != 1 || ov_m != load4_m + 9) begin
            n_bad++;
            $display("FAIL overrun_pulse got n=%0d at=%0d exp n=1 at=%0d", n_ov, ov_m, load4_m + 9);
        end
        n_cmp++;
        if (wr_seq !== 16'h271B || n_done != 1) begin
            n_bad++;
            $display("FAIL overrun_schedule got seq=%04h done=%0d exp seq=271b done=1", wr_seq, n_done);
        end
        n_cmp++;
        if (n_ld != 5 || first_after != 0) begin
            n_bad++;
            $display("FAIL overrun_next_frame got loads=%0d addr=%0d exp loads=5 addr=0", n_ld, first_after);
        end
    endtask

    task automatic test_reset_mid;
        logic v;
        bit   hit;
        int   n_done;
        hit = 0; n_done = 0;
        apply_reset();
        rq.delete();
        repeat (4) add_pulse(3, 3);
        for (int i = 0; i < 60 && !hit; i++) begin
            v = (rq.size() > 0) ? rq.pop_front() : 1'b0;
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL mid_pre m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (nloads == 4 && m == last_l + 5) hit = 1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL mid_reach got=0 exp=1 (stage1 butterfly 2 phase 1 not reached)");
        end else if ({rd_a_addr, rd_b_addr, wr_en, wr_addr, alu_op} !== {2'd1, 2'd3, 1'b1, 2'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_at_p1 got a=%0d b=%0d wr=%b wa=%0d op=%b exp 1 3 1 1 0",
                     rd_a_addr, rd_b_addr, wr_en, wr_addr, alu_op);
        end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 20'h0) begin
            n_bad++;
            $display("FAIL mid_async_clear got=%05h exp=%05h", obs, 20'h0);
        end
        run_cycle(1'b0);
        n_rst = 1'b1;
        rq.delete();
        repeat (4) add_pulse(3, 3);
        add_pulse(0, 20);
        while (rq.size() > 0) begin
            v = rq.pop_front();
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL mid_fresh m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 1) begin
            n_bad++;
            $display("FAIL mid_fresh_done got=%0d exp=1", n_done);
        end
    endtask

    task automatic test_held_high;
        int  n_ld, ld_m, ld_addr, n_done;
        logic v;
        n_ld = 0; ld_m = -1; ld_addr = -1; n_done = 0;
        readyin = 1'b1;
        n_rst   = 1'b0;
        run_cycle(1'b1);
        run_cycle(1'b1);
        n_rst = 1'b1;
        repeat (12) begin
            run_cycle(1'b1);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL held_cycle m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (load_en === 1'b1) begin n_ld++; ld_m = m; ld_addr = int'(in_addr); end
        end
        n_cmp++;
        if (n_ld != 1 || ld_m != 3 || ld_addr != 0) begin
            n_bad++;
            $display("FAIL held_load got n=%0d at=%0d addr=%0d exp n=1 at=3 addr=0", n_ld, ld_m, ld_addr);
        end
        rq.delete();
        add_pulse(0, 3);
        repeat (3) add_pulse(3, 3);
        add_pulse(0, 20);
        while (rq.size() > 0) begin
            v = rq.pop_front();
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL held_rest m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
            if (done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 1) begin
            n_bad++;
            $display("FAIL held_done got=%0d exp=1", n_done);
        end
    endtask

    task automatic test_random;
        logic v;
        apply_reset();
        rq.delete();
        while (rq.size() < 400) add_pulse(int'($urandom_range(2, 4)), int'($urandom_range(2, 12)));
        add_pulse(0, 20);
        while (rq.size() > 0) begin
            v = rq.pop_front();
            run_cycle(v);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL random_cycle m=%0d got=%05h exp=%05h", m, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_reset_mid();
        test_held_high();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
